// File: rtl/ram_rmw_engine_pkg.sv
// ram_rmw_engine_pkg
// Shared definitions for the read-modify-write engine: the request opcode
// encoding seen on req_op and the two-state control FSM encoding.
// No ports; imported by ram_rmw_engine and rmw_alu.

package ram_rmw_engine_pkg;

    // Opcode carried on req_op. READ is a pure fetch and never writes back.
    typedef enum logic [1:0] {
        RMW_OP_ADD  = 2'd0,
        RMW_OP_SUB  = 2'd1,
        RMW_OP_SET  = 2'd2,
        RMW_OP_READ = 2'd3
    } rmw_op_e;

    // INIT zeroes the RAM after reset; RUN serves requests.
    typedef enum logic {
        RMW_ST_INIT = 1'b0,
        RMW_ST_RUN  = 1'b1
    } rmw_state_e;

endpackage

// File: rtl/ram_rmw_engine_alu.sv
// rmw_alu
// Purely combinational update function of the engine: given the opcode, the
// current entry value and the request operand, produce the value to store.
// Optional macro RMW_SATURATE_EN: ADD clamps to all-ones on unsigned
// overflow and SUB clamps to zero on underflow; otherwise both wrap.
// Ports:
//   op_i    opcode (rmw_op_e encoding)
//   old_i   entry value before the operation
//   data_i  operand (delta or value to set)
//   new_o   entry value after the operation

module rmw_alu
    import ram_rmw_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] new_o
);

    logic [DATA_WIDTH-1:0] add_res;
    logic [DATA_WIDTH-1:0] sub_res;

`ifdef RMW_SATURATE_EN
    // One extra bit exposes the carry of the add and the borrow of the subtract.
    logic [DATA_WIDTH:0] add_wide;
    logic [DATA_WIDTH:0] sub_wide;

    assign add_wide = {1'b0, old_i} + {1'b0, data_i};
    assign sub_wide = {1'b0, old_i} - {1'b0, data_i};
    assign add_res  = add_wide[DATA_WIDTH] ? '1 : add_wide[DATA_WIDTH-1:0];
    assign sub_res  = sub_wide[DATA_WIDTH] ? '0 : sub_wide[DATA_WIDTH-1:0];
`else
    assign add_res = old_i + data_i;
    assign sub_res = old_i - data_i;
`endif

    always_comb begin
        new_o = old_i;
        case (rmw_op_e'(op_i))
            RMW_OP_ADD:  new_o = add_res;
            RMW_OP_SUB:  new_o = sub_res;
            RMW_OP_SET:  new_o = data_i;
            RMW_OP_READ: new_o = old_i;
            default:     new_o = old_i;
        endcase
    end

endmodule

// File: rtl/ram_rmw_engine.sv
// ram_rmw_engine
// Initiator-side client owning one read port and one write port of a
// synchronous (1-cycle read latency, read-old-on-collision) RAM. After reset
// it zeroes every entry, then accepts one atomic ADD/SUB/SET/READ per cycle.
// A one-deep write-to-read bypass keeps back-to-back ops to one entry coherent.
// Optional macro RMW_SATURATE_EN (inside rmw_alu): saturating ADD/SUB.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   init_done                         zeroing sweep finished
//   req_val/req_rdy/req_op/req_addr/req_data   request channel
//   resp_val/resp_addr/resp_old/resp_new       response, 2 cycles after accept
//   ram_r_val/ram_r_addr/ram_r_data            RAM read port
//   ram_w_val/ram_w_addr/ram_w_data            RAM write port

module ram_rmw_engine
    import ram_rmw_engine_pkg::*;
#(
    parameter int RAM_DEPTH      = 128,
    parameter int RAM_ADDR_WIDTH = 7,
    parameter int RAM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      init_done,
    input  logic                      req_val,
    output logic                      req_rdy,
    input  logic [1:0]                req_op,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req_data,
    output logic                      resp_val,
    output logic [RAM_ADDR_WIDTH-1:0] resp_addr,
    output logic [RAM_DATA_WIDTH-1:0] resp_old,
    output logic [RAM_DATA_WIDTH-1:0] resp_new,
    output logic                      ram_r_val,
    output logic [RAM_ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_r_data,
    output logic                      ram_w_val,
    output logic [RAM_ADDR_WIDTH-1:0] ram_w_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_w_data
);

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);

    rmw_state_e                state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] sweep_q, sweep_d;

    logic                      s1_val_q;
    rmw_op_e                   s1_op_q;
    logic [RAM_ADDR_WIDTH-1:0] s1_addr_q;
    logic [RAM_DATA_WIDTH-1:0] s1_data_q;

    logic                      byp_val_q;
    logic [RAM_ADDR_WIDTH-1:0] byp_addr_q;
    logic [RAM_DATA_WIDTH-1:0] byp_data_q;

    logic                      resp_val_q;
    logic [RAM_ADDR_WIDTH-1:0] resp_addr_q;
    logic [RAM_DATA_WIDTH-1:0] resp_old_q;
    logic [RAM_DATA_WIDTH-1:0] resp_new_q;

    logic                      accept;
    logic                      s1_hit;
    logic                      s1_write;
    logic [RAM_DATA_WIDTH-1:0] s1_old;
    logic [RAM_DATA_WIDTH-1:0] s1_new;

    // Stage 0: the RAM read is launched in the same cycle the request is taken.
    assign accept     = req_val & req_rdy;
    assign ram_r_val  = accept;
    assign ram_r_addr = req_addr;

    // The RAM returns stale data for an entry written in the previous cycle,
    // so that write's value is taken from the bypass register instead.
    assign s1_hit   = byp_val_q && (byp_addr_q == s1_addr_q);
    assign s1_old   = s1_hit ? byp_data_q : ram_r_data;
    assign s1_write = s1_val_q && (s1_op_q != RMW_OP_READ);

    rmw_alu #(
        .DATA_WIDTH (RAM_DATA_WIDTH)
    ) u_alu (
        .op_i   (s1_op_q),
        .old_i  (s1_old),
        .data_i (s1_data_q),
        .new_o  (s1_new)
    );

    // Control FSM and write-port mux. The sweep write is gated by rst_n so the
    // write port stays quiet while reset is held and starts on the first
    // cycle after release.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        req_rdy    = 1'b0;
        init_done  = 1'b0;
        ram_w_val  = 1'b0;
        ram_w_addr = s1_addr_q;
        ram_w_data = s1_new;
        case (state_q)
            RMW_ST_INIT: begin
                ram_w_val  = rst_n;
                ram_w_addr = sweep_q;
                ram_w_data = '0;
                sweep_d    = sweep_q + RAM_ADDR_WIDTH'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = RMW_ST_RUN;
                    sweep_d = '0;
                end
            end
            RMW_ST_RUN: begin
                req_rdy   = 1'b1;
                init_done = 1'b1;
                ram_w_val = s1_write;
            end
            default: state_d = RMW_ST_INIT;
        endcase
    end

    // Pipeline, bypass and response registers. Reset drops any op sitting in
    // stage 1, so it produces neither a write nor a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RMW_ST_INIT;
            sweep_q     <= '0;
            s1_val_q    <= 1'b0;
            s1_op_q     <= RMW_OP_READ;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            byp_val_q   <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
            resp_val_q  <= 1'b0;
            resp_addr_q <= '0;
            resp_old_q  <= '0;
            resp_new_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            s1_val_q   <= accept;
            if (accept) begin
                s1_op_q   <= rmw_op_e'(req_op);
                s1_addr_q <= req_addr;
                s1_data_q <= req_data;
            end
            byp_val_q  <= s1_write;
            byp_addr_q <= s1_addr_q;
            byp_data_q <= s1_new;
            resp_val_q <= s1_val_q;
            if (s1_val_q) begin
                resp_addr_q <= s1_addr_q;
                resp_old_q  <= s1_old;
                resp_new_q  <= s1_new;
            end
        end
    end

    assign resp_val  = resp_val_q;
    assign resp_addr = resp_addr_q;
    assign resp_old  = resp_old_q;
    assign resp_new  = resp_new_q;

endmodule

// File: doc/ram_rmw_engine.md
Name: ram_rmw_engine

Overview:
- Initiator-side client for the multi-port RAM blocks (ram_2w2r / ram_2w4r family): owns one read port and one write port of a RAM instance.
- Accepts atomic read-modify-write requests (add/sub/set/read) on per-entry state, e.g. per-flow counters. Throughput is 1 op/cycle.
- Provides a one-deep write-to-read bypass so back-to-back ops to the same address are coherent.
- Runs a post-reset sweep that zeroes every entry before accepting requests.

Parameters:
RAM_DEPTH, 128, number of entries swept at init and addressable
RAM_ADDR_WIDTH, 7, address width, clog2(RAM_DEPTH)
RAM_DATA_WIDTH, 32, entry and operand width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
init_done  out  1  high once the zeroing sweep completes
req_val  in  1  request valid
req_rdy  out  1  engine can accept; transfer on req_val&req_rdy
req_op  in  2  0=ADD 1=SUB 2=SET 3=READ
req_addr  in  RAM_ADDR_WIDTH  target entry
req_data  in  RAM_DATA_WIDTH  operand (delta or set value)
resp_val  out  1  response valid, one cycle pulse per op
resp_addr  out  RAM_ADDR_WIDTH  address of the completed op
resp_old  out  RAM_DATA_WIDTH  value before the op
resp_new  out  RAM_DATA_WIDTH  value after the op
ram_r_val  out  1  to RAM read port valid
ram_r_addr  out  RAM_ADDR_WIDTH  to RAM read port address
ram_r_data  in  RAM_DATA_WIDTH  RAM read data, valid the cycle after ram_r_val
ram_w_val  out  1  to RAM write port valid
ram_w_addr  out  RAM_ADDR_WIDTH  to RAM write port address
ram_w_data  out  RAM_DATA_WIDTH  to RAM write port data

Behaviour:
- RAM contract: synchronous read, 1-cycle latency. A read and a write to the same address in the same cycle return the old data.
- FSM states: INIT, RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - Each cycle: ram_w_val=1, ram_w_addr=counter, ram_w_data=0; counter increments.
  - After writing RAM_DEPTH-1, go to RUN next cycle. The sweep takes exactly RAM_DEPTH cycles.
  - req_rdy=0 and init_done=0 throughout.
- RUN:
  - req_rdy=1 constantly; init_done=1.
- Stage 0 (cycle T, combinational):
  - ram_r_val = req_val & req_rdy; ram_r_addr = req_addr.
  - On transfer, op/addr/data are registered into stage 1.
- Stage 1 (cycle T+1):
  - old = bypass hit ? byp_data : ram_r_data.
  - Bypass register holds {valid, addr, data} of the write issued in the previous cycle. Hit = byp_valid & byp_addr==s1_addr.
  - new: ADD old+data; SUB old-data; SET data; READ old. Arithmetic is modulo 2^RAM_DATA_WIDTH.
  - Write issued combinationally for ADD/SUB/SET: ram_w_val=1, addr=s1_addr, data=new. READ issues no write.
  - Bypass register loads this write: valid=write issued, addr, new.
- Response: registered from stage 1, so resp_val is high at T+2 (latency 2 from acceptance). No backpressure on the response.
- Same address on consecutive cycles: the second op sees the first op's new value through the bypass. Ops two or more cycles apart see RAM contents directly; no bypass is needed.
- Reset values: resp_val=0, resp_addr/old/new=0, ram_r_val=0, ram_w_val=0 (driven by INIT from the first post-reset cycle), init_done=0, req_rdy=0, bypass valid=0.
- Reset mid-operation:
  - Any in-flight stage-1 op is dropped; no response and no write.
  - The sweep restarts from address 0.
- req_val while req_rdy=0: ignored; no read issued.

Optional Feature:
- Macro RMW_SATURATE_EN.
- Defined: ADD clamps to all-ones on unsigned overflow, and SUB clamps to 0 on underflow.
- Undefined: ADD and SUB wrap modulo 2^RAM_DATA_WIDTH.
- SET and READ are unaffected either way.

Decomposition:
- Shared package holds:
  - op encoding constants RMW_OP_ADD/SUB/SET/READ;
  - FSM state encoding RMW_ST_INIT/RMW_ST_RUN.
- One sub-module, rmw_alu: purely combinational, (op, old, data) -> new. The saturation option lives inside it.
- Integration: top instantiates ram_rmw_engine next to a ram_2w4r, using one read port and one write port of it.

Test Plan:
- Reset, 128-entry default: ram_w_val high with addr 0..127 and data 0 for 128 cycles, then init_done=1; req_val asserted during INIT issues no ram_r_val.
- ADD addr 5 data 3, idle, READ addr 5: responses give old=0/new=3, then old=3/new=3; resp_val appears exactly 2 cycles after each acceptance.
- Back-to-back ADD addr 9 data 1 for 4 consecutive cycles: resp_new sequence 1,2,3,4, exercising the bypass every cycle.
- Interleave ADD addr 2 data 10 / ADD addr 3 data 20 / ADD addr 2 data 5: addr 2 ends at 15 and addr 3 at 20; no false bypass hit.
- SET addr 7 to 0xFFFFFFFF, then ADD addr 7 data 2: new=1 without the macro, 0xFFFFFFFF with RMW_SATURATE_EN; SUB 5 from 0 gives 0xFFFFFFFB or 0 respectively.
- Assert rst_n low while an ADD is in stage 1: no resp_val and no ram_w_val for that op; the sweep restarts at addr 0 and the entry reads 0 after init.
